// File: rtl/bit_stream_serializer_if.sv
// bit_stream_serializer_if: word handshake and serial output bundle for bit_stream_serializer
// master: upstream/consumer side (drives in_valid, in_data)
// slave : serializer side (drives in_ready, ser_out, ser_valid, busy, frame_done)
interface bit_stream_serializer_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             frame_done;
  modport master (output in_valid, in_data, input in_ready, ser_out, ser_valid, busy, frame_done);
  modport slave  (input in_valid, in_data, output in_ready, ser_out, ser_valid, busy, frame_done);
endinterface

// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer: parallel-to-serial stage feeding the 1010 detector's x input
// Ports: clk, rst (async, active-high), s (bit_stream_serializer_if.slave):
//   in_valid/in_ready/in_data word handshake, ser_out serial bit, ser_valid bit
//   qualifier, busy word in flight, frame_done pulse on a word's final bit.
// Optional macro SER_PARITY_EN appends one even-parity bit after each word.
module bit_stream_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input logic clk,
  input logic rst,
  bit_stream_serializer_if.slave s
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t state, state_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic last, fin, hs;
`ifdef SER_PARITY_EN
  logic par, par_nxt;
  assign fin = state == PARITY;
`else
  assign fin = last;
`endif
  assign last = state == SHIFT && cnt == LAST;
  assign s.in_ready = !rst && (state == IDLE || fin);
  assign hs = s.in_valid && s.in_ready;
  // outputs depend only on registered state, never on in_*
  assign s.frame_done = fin;
  assign s.ser_valid = state != IDLE;
  assign s.busy = state != IDLE;
`ifdef SER_PARITY_EN
  assign s.ser_out = state == SHIFT ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : state == PARITY ? par : IDLE_LEVEL;
`else
  assign s.ser_out = state == SHIFT ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : IDLE_LEVEL;
`endif
  always_comb begin
    state_nxt = state;
    sh_nxt = sh;
    cnt_nxt = cnt;
`ifdef SER_PARITY_EN
    par_nxt = par;
    state_nxt = state == SHIFT ? (last ? PARITY : SHIFT) : IDLE;
`else
    state_nxt = state == SHIFT && !last ? SHIFT : IDLE;
`endif
    if (state == SHIFT && !last) begin
      sh_nxt = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
      cnt_nxt = cnt + 1'b1;
    end
    // a handshake is only possible when idle or on a word's final cycle, so it overrides
    if (hs) begin
      state_nxt = SHIFT;
      sh_nxt = s.in_data;
      cnt_nxt = '0;
`ifdef SER_PARITY_EN
      par_nxt = ^s.in_data;
`endif
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
`ifdef SER_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      sh <= sh_nxt;
      cnt <= cnt_nxt;
`ifdef SER_PARITY_EN
      par <= par_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_bit_stream_serializer.sv
// tb_bit_stream_serializer: directed self-checking bench for bit_stream_serializer
module tb_bit_stream_serializer;
`ifdef SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = 8 + PAR;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  bit_stream_serializer_if #(.WIDTH(8)) f0 ();
  bit_stream_serializer_if #(.WIDTH(8)) f1 ();
  bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (.clk(clk), .rst(rst), .s(f0.slave));
  bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (.clk(clk), .rst(rst), .s(f1.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_chk(input bit lsb, input string tag);
    check({tag, "_out"}, lsb ? f1.ser_out : f0.ser_out, 0);
    check({tag, "_valid"}, lsb ? f1.ser_valid : f0.ser_valid, 0);
    check({tag, "_busy"}, lsb ? f1.busy : f0.busy, 0);
    check({tag, "_rdy"}, lsb ? f1.in_ready : f0.in_ready, 1);
    check({tag, "_fd"}, lsb ? f1.frame_done : f0.frame_done, 0);
  endtask
  // checks n serial cycles against exp (first bit at exp[n-1]); drops in_valid after cycle drop_at
  task automatic stream(input bit lsb, input string tag, input logic [31:0] exp, input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      logic fe;
      fe = (i % FL) == FL - 1;
      check({tag, "_bit"}, lsb ? f1.ser_out : f0.ser_out, exp[n-1-i]);
      check({tag, "_valid"}, lsb ? f1.ser_valid : f0.ser_valid, 1);
      check({tag, "_busy"}, lsb ? f1.busy : f0.busy, 1);
      check({tag, "_fd"}, lsb ? f1.frame_done : f0.frame_done, fe);
      check({tag, "_rdy"}, lsb ? f1.in_ready : f0.in_ready, fe);
      tick();
      if (i == drop_at) begin
        if (lsb) f1.in_valid = 1'b0;
        else f0.in_valid = 1'b0;
      end
    end
    idle_chk(lsb, {tag, "_end"});
  endtask
  initial begin
    f0.in_valid = 1'b0;
    f0.in_data = '0;
    f1.in_valid = 1'b0;
    f1.in_data = '0;
    #2;
    check("rst_out", f0.ser_out, 0);
    check("rst_valid", f0.ser_valid, 0);
    check("rst_busy", f0.busy, 0);
    check("rst_rdy", f0.in_ready, 0);
    check("rst_fd", f0.frame_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_rdy", f0.in_ready, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      idle_chk(0, "idle");
      tick();
    end
    f0.in_valid = 1'b1;
    f0.in_data = 8'hA0;
    check("a0_rdy0", f0.in_ready, 1);
    tick();
    f0.in_valid = 1'b0;
    stream(0, "a0", PAR ? 32'h140 : 32'hA0, FL, -1);
    f0.in_valid = 1'b1;
    f0.in_data = 8'hAA;
    tick();
    f0.in_data = 8'h55;
    stream(0, "b2b", PAR ? 32'h2A8AA : 32'hAA55, 2 * FL, FL - 1);
    f1.in_valid = 1'b1;
    f1.in_data = 8'h05;
    tick();
    f1.in_valid = 1'b0;
    stream(1, "lsb05", PAR ? 32'h140 : 32'hA0, FL, -1);
    f0.in_valid = 1'b1;
    f0.in_data = 8'hFF;
    tick();
    f0.in_valid = 1'b0;
    tick();
    tick();
    check("mid_bit3", f0.ser_out, 1);
    rst = 1'b1;
    #1;
    check("mid_out", f0.ser_out, 0);
    check("mid_valid", f0.ser_valid, 0);
    check("mid_busy", f0.busy, 0);
    check("mid_rdy", f0.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rel_rdy", f0.in_ready, 1);
    check("mid_rel_valid", f0.ser_valid, 0);
    tick();
    f0.in_valid = 1'b1;
    f0.in_data = 8'h80;
    tick();
    f0.in_valid = 1'b0;
    stream(0, "w80", PAR ? 32'h101 : 32'h80, FL, -1);
`ifdef SER_PARITY_EN
    f0.in_valid = 1'b1;
    f0.in_data = 8'h07;
    tick();
    f0.in_valid = 1'b0;
    stream(0, "par07", 32'h00F, 9, -1);
`endif
    tick();
    idle_chk(0, "final");
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bit_stream_serializer.md
Name: bit_stream_serializer

Overview:
- Parallel-to-serial stage directly upstream of the 1010 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on ser_out, which drives the detector's serial input x.
- Supports gapless back-to-back words, so the detector sees a continuous bit stream and can match patterns across word boundaries.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = send in_data[WIDTH-1] first; 0 = send in_data[0] first.
- IDLE_LEVEL, 0, value driven on ser_out when no bit is being sent.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word to serialize; sampled only on handshake.
- ser_out  output  1  serial bit to the detector's x input.
- ser_valid  output  1  ser_out carries a payload or parity bit this cycle.
- busy  output  1  high while a word (or its parity) is in flight.
- frame_done  output  1  one-cycle pulse in the cycle the final bit of a word is on ser_out.

Behaviour:
- Clock and reset
  - All registers update on the rising edge of clk. The detector samples x on the falling edge, so ser_out is stable half a cycle before the detector samples it.
  - Reset is asynchronous and active-high. While rst=1: state=IDLE, shift register=0, bit counter=0, ser_out=IDLE_LEVEL, ser_valid=0, frame_done=0, busy=0, in_ready=0.
  - in_ready rises combinationally once rst deasserts.
- State machine: IDLE, SHIFT, and PARITY (PARITY exists only with the optional feature).
- Handshake
  - A word is accepted on a rising edge where in_valid=1 and in_ready=1.
  - in_ready is combinational: 1 in IDLE, 1 in the final-bit cycle of a word, 0 otherwise.
  - in_data and in_valid are ignored whenever in_ready=0.
- Latency: for a word accepted at edge N, its first bit appears on ser_out in the cycle after edge N and stays for one cycle. Each remaining bit follows on consecutive cycles, WIDTH cycles in total.
- Transitions and outputs
  - IDLE, handshake: load shift register, counter=0, go to SHIFT. ser_valid=1 and busy=1 from the next cycle.
  - SHIFT, not final bit: shift one position toward the output end, counter+1.
  - SHIFT, final bit (counter==WIDTH-1), no parity:
    - frame_done=1 in this cycle.
    - If a handshake occurs at this edge, the new word loads and SHIFT continues with no gap (ser_valid stays 1).
    - Otherwise go to IDLE: ser_out=IDLE_LEVEL, ser_valid=0, busy=0.
- Bit counter width: $clog2(WIDTH); it must not wrap before WIDTH-1 is detected.
- ser_out, ser_valid and frame_done are registered outputs, with no combinational path from in_* to them.
- Reset mid-word aborts the word with no resumption. The bits are lost, and the next accepted word starts from its first bit.

Optional Feature:
- Macro: SER_PARITY_EN
- Defined
  - After the last payload bit the FSM enters PARITY for one cycle and drives ser_out = even parity (XOR of the accepted word) with ser_valid=1.
  - frame_done pulses in the PARITY cycle instead of the last payload cycle.
  - in_ready is 1 in the PARITY cycle and 0 in the last payload cycle; back-to-back words remain gapless.
- Undefined: no PARITY state or parity logic is built; behaviour is exactly as described above.

Test Plan:
- Reset then idle for 5 cycles, in_valid=0 -> ser_out=0, ser_valid=0, busy=0, in_ready=1, frame_done never pulses.
- MSB_FIRST=1, single word 8'hA0 -> ser_out sequence 1,0,1,0,0,0,0,0 with ser_valid=1 for exactly 8 cycles. frame_done pulses on the 8th cycle; ser_out=0 and in_ready=1 on the 9th.
- Back-to-back: in_valid held with 8'hAA then 8'h55 -> 16 contiguous valid bits 1010101001010101. in_ready=1 only in IDLE and in cycles 8 and 16. Two frame_done pulses, at cycles 8 and 16.
- MSB_FIRST=0, word 8'h05 -> ser_out sequence 1,0,1,0,0,0,0,0.
- Mid-word reset: send 8'hFF and assert rst during the 3rd bit -> ser_out=0 and ser_valid=0 immediately, without waiting for a clock. After release, word 8'h80 is sent as 1 followed by seven 0s.
- With SER_PARITY_EN defined, word 8'h07 -> 9 valid bits 0,0,0,0,0,1,1,1,1, where the 9th bit is parity (three ones, so 1). frame_done and in_ready are high in cycle 9 only.
